// File: rtl/pbit_state_histogram.sv
// Hardware sampler for p-bit networks: sweep-rate tick divider, burn-in,
// and a saturating per-state histogram with a registered read port.
module pbit_state_histogram #(
    parameter int N            = 5,
    parameter int SWEEP_CYCLES = 15,
    parameter int CNT_W        = 16,
    parameter int SMP_W        = 20
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [SMP_W-1:0] i_num_samples,
    input  logic [SMP_W-1:0] i_burn_in,
    input  logic [N-1:0]     i_state_in,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_tick,
    output logic             o_overflow,
    output logic [SMP_W-1:0] o_samples_taken,
    input  logic [N-1:0]     i_rd_addr,
    output logic [CNT_W-1:0] o_rd_data
);

    localparam int NBINS = 1 << N;
    localparam int DIV_W = (SWEEP_CYCLES > 1) ? $clog2(SWEEP_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SWEEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [N-1:0]     CLR_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_BURN,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_clr_idx;
    logic [DIV_W-1:0] r_div;
    logic [SMP_W-1:0] r_num;
    logic [SMP_W-1:0] r_burn;
    logic [SMP_W-1:0] r_burn_cnt;
    logic [SMP_W-1:0] r_smp;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_bins [NBINS];
    logic [CNT_W-1:0] r_rd_data;

    logic             w_sweeping;
    logic             w_tick;
    logic [CNT_W-1:0] w_bin;
    logic             w_bin_sat;
    logic             w_clr_we;
    logic             w_inc_we;

    assign w_sweeping = (r_state == S_BURN) || (r_state == S_RUN);
    assign w_tick     = w_sweeping && (r_div == DIV_LAST);
    assign w_bin      = r_bins[i_state_in];
    assign w_bin_sat  = (w_bin == CNT_MAX);
    assign w_clr_we   = (r_state == S_CLEAR) && !i_abort;
    assign w_inc_we   = (r_state == S_RUN) && w_tick && !i_abort && !w_bin_sat;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_clr_idx  <= '0;
            r_div      <= '0;
            r_num      <= '0;
            r_burn     <= '0;
            r_burn_cnt <= '0;
            r_smp      <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (i_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state   <= S_CLEAR;
                        r_num     <= i_num_samples;
                        r_burn    <= i_burn_in;
                        r_smp     <= '0;
                        r_ovf     <= 1'b0;
                        r_clr_idx <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == CLR_LAST) begin
                        r_div      <= '0;
                        r_burn_cnt <= '0;
                        if (r_burn != '0) begin
                            r_state <= S_BURN;
                        end else if (r_num != '0) begin
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_BURN: begin
                    r_div <= w_tick ? '0 : r_div + 1'b1;
                    if (w_tick) begin
                        r_burn_cnt <= r_burn_cnt + 1'b1;
                        if (r_burn_cnt + 1'b1 == r_burn) begin
                            if (r_num != '0) begin
                                r_state <= S_RUN;
                            end else begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                S_RUN: begin
                    r_div <= w_tick ? '0 : r_div + 1'b1;
                    if (w_tick) begin
                        r_smp <= r_smp + 1'b1;
                        if (w_bin_sat) begin
                            r_ovf <= 1'b1;
                        end
                        if (r_smp + 1'b1 == r_num) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Saturated bins simply skip the write; overflow is flagged in the FSM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NBINS; i++) begin
                r_bins[i] <= '0;
            end
        end else if (w_clr_we) begin
            r_bins[r_clr_idx] <= '0;
        end else if (w_inc_we) begin
            r_bins[i_state_in] <= w_bin + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_bins[i_rd_addr];
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_tick          = w_tick;
    assign o_overflow      = r_ovf;
    assign o_samples_taken = r_smp;
    assign o_rd_data       = r_rd_data;

endmodule

// File: doc/pbit_state_histogram.md
# pbit_state_histogram

Synthesizable on-chip sampler for p-bit networks. It divides CLK into one sample tick per full network sweep and discards a programmable burn-in. It then accumulates a saturating histogram of the N-bit network state over a programmable number of samples and exposes the bins through a registered read port. It sits beside the p-bit array top level, replacing bench-side counting with hardware statistics usable in silicon and long runs.

## Interface
- N, 5, number of p-bits; histogram has 2^N bins.
- SWEEP_CYCLES, 15, CLK cycles per sample tick (N × cycles per p-bit update); must be ≥ 1.
- CNT_W, 16, bin counter width.
- SMP_W, 20, width of num_samples, burn_in, sample counters.

- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse, begins a run; ignored unless in IDLE or DONE.
- abort  in  1  returns to IDLE from any state; bins keep current contents.
- num_samples  in  SMP_W  samples to accumulate; latched on accepted start.
- burn_in  in  SMP_W  ticks to discard before counting; latched on accepted start.
- state_in  in  N  current p-bit network state.
- busy  out  1  high in CLEAR, BURN, RUN.
- done  out  1  high in DONE.
- tick  out  1  one-cycle pulse on each sample tick in BURN/RUN.
- overflow  out  1  sticky; set when any bin saturates; cleared in CLEAR.
- samples_taken  out  SMP_W  samples counted in current/last run.
- rd_addr  in  N  bin to read.
- rd_data  out  CNT_W  contents of bin rd_addr, registered.

## Operation
- FSM states: IDLE, CLEAR, BURN, RUN, DONE.
- IDLE/DONE + start → CLEAR. Latch num_samples and burn_in. Zero samples_taken and overflow.
- CLEAR: write 0 to bin index clr_idx, one bin per cycle, clr_idx 0..2^N−1. After the last bin:
  - → BURN if latched burn_in ≠ 0;
  - else → RUN if num_samples ≠ 0;
  - else → DONE.
- Divider counter: reset to 0 on entry to BURN or RUN from CLEAR. Increments each cycle in BURN/RUN. tick asserts when counter = SWEEP_CYCLES−1, then counter wraps to 0. Counter is not reset on BURN→RUN, so tick spacing stays exactly SWEEP_CYCLES.
- BURN: count ticks. On the burn_in-th tick → RUN, or → DONE if num_samples = 0. The burn tick is not recorded.
- RUN: on each tick, bin[state_in] += 1 and samples_taken += 1. On the tick that makes samples_taken = num_samples → DONE.
- Saturation: a bin at 2^CNT_W−1 holds its value. overflow is set on that tick.
- DONE: hold bins, samples_taken and overflow until the next start.
- abort has priority over start and over every transition. It forces IDLE. busy and done fall the next cycle.
- Simultaneous start and abort: abort wins, start is ignored.
- start while busy: ignored; latched parameters unchanged.
- RST: FSM → IDLE. All bins, counters, busy, done, tick, overflow, samples_taken and rd_data → 0.

## Timing
- start sampled at edge k → busy high after edge k. CLEAR occupies 2^N cycles.
- First tick occurs SWEEP_CYCLES cycles after CLEAR exits.
- state_in is sampled on the tick cycle. The bin update is visible in rd_data at the earliest 2 cycles after the tick edge (write edge + read register).
- rd_data = bin[rd_addr] as of the previous edge. A read of a bin being written in the same cycle returns the old value.
- Reads are legal in every state. During CLEAR, rd_data reflects partially cleared contents.
- done rises on the edge that records the final sample.
- Total run length: 2^N + SWEEP_CYCLES × (burn_in + num_samples) cycles from start acceptance to done.

## Test plan
- Constant state: N=3, SWEEP_CYCLES=15, burn_in=0, num_samples=10, state_in=3'd5 → done after 8+150 cycles; bin5=10, all other bins 0, samples_taken=10, overflow=0.
- Burn-in discard: state_in=2 for the first 4 ticks then 6, burn_in=4, num_samples=6 → bin2=0, bin6=6. Tick spacing is 15 cycles across BURN→RUN.
- Saturation: CNT_W=4, constant state 1, num_samples=20 → bin1=15, overflow=1, samples_taken=20.
- Abort mid-RUN after 3 samples → IDLE next cycle, busy=0, done=0, bins retain 3 counts. A new start clears all bins to 0.
- Zero samples: num_samples=0, burn_in=0 → DONE directly after CLEAR, all bins 0. start during busy is ignored (check latched num_samples unchanged).
- RST asserted during RUN → next cycle all outputs 0 and state IDLE. rd_data for every rd_addr reads 0.
